// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-access stage: controller state
// encoding, register-zero constant, default timeout, alignment mask.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         TIMEOUT_DEF = 16;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/mem_req_fsm.sv
// IDLE/ACCESS/DONE controller for the data-memory port. Holds dm_req while
// an access is outstanding, counts request cycles and aborts when the
// count reaches TIMEOUT-1 without an acknowledge.
module mem_req_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start_i,
    input  logic dm_ack_i,
    output logic dm_req_o,
    output logic stall_o,
    output logic ack_done_o,
    output logic timeout_o
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and timeout counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and decoded controls; ack wins over timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dm_req_o   = 1'b0;
        stall_o    = 1'b0;
        ack_done_o = 1'b0;
        timeout_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dm_req_o = 1'b1;
                stall_o  = 1'b1;
                if (dm_ack_i) begin
                    ack_done_o = 1'b1;
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_o = 1'b1;
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                stall_o = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM boundary: captures the execute bundle, resolves branches, runs
// loads/stores over the req/ack data-memory port and drives the registered
// writeback bundle and exception pulses.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ex_valid,
    input  logic [31:0]   alu_out,
    input  logic [31:0]   bb,
    input  logic          mw,
    input  logic          mr,
    input  logic          br,
    input  logic          rw_en,
    input  logic [4:0]    rw,
    input  logic          zero,
    input  logic          overflow,
    input  logic [31:0]   new_pc,
    output logic          stall,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    input  logic          dm_ack,
    output logic          pc_src,
    output logic [31:0]   pc_target,
    output logic          wb_valid,
    output logic          wb_we,
    output logic [4:0]    wb_rw,
    output logic [31:0]   wb_data,
    output logic          ovf_exc,
    output logic          align_exc,
    output logic          bus_err
);

    logic accept, is_mem, misalign, start, wb_we_base;
    logic fsm_req, fsm_stall, ack_done, timeout_hit;

    // Pending-access context, valid while the controller is busy.
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [31:0]   alu_q, alu_d;
    logic [4:0]    rw_q, rw_d;
    logic          we_q, we_d, wbwe_q, wbwe_d, ovf_q, ovf_d;

    // Registered writeback, branch and exception outputs.
    logic          wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [4:0]    wb_rw_q, wb_rw_d;
    logic [31:0]   wb_data_q, wb_data_d, pc_target_q, pc_target_d;
    logic          pc_src_q, pc_src_d, ovf_exc_q, ovf_exc_d;
    logic          align_exc_q, align_exc_d, bus_err_q, bus_err_d;

    assign accept     = ex_valid & ~fsm_stall;
    assign is_mem     = mw | mr;
    assign misalign   = |(alu_out[1:0] & ALIGN_MASK);
    assign start      = accept & is_mem & ~misalign;
    assign wb_we_base = rw_en & ~overflow & (rw != REG_ZERO);

    mem_req_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (start),
        .dm_ack_i   (dm_ack),
        .dm_req_o   (fsm_req),
        .stall_o    (fsm_stall),
        .ack_done_o (ack_done),
        .timeout_o  (timeout_hit)
    );

    // Capture on accept; writeback either straight from the bundle (no access
    // needed) or from the pending context when the access completes/aborts.
    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        alu_d       = alu_q;
        rw_d        = rw_q;
        we_d        = we_q;
        wbwe_d      = wbwe_q;
        ovf_d       = ovf_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = wb_we_q;
        wb_rw_d     = wb_rw_q;
        wb_data_d   = wb_data_q;
        pc_src_d    = 1'b0;
        pc_target_d = pc_target_q;
        ovf_exc_d   = 1'b0;
        align_exc_d = 1'b0;
        bus_err_d   = 1'b0;
        if (accept) begin
            addr_d      = alu_out[AW-1:0];
            wdata_d     = DW'(bb);
            alu_d       = alu_out;
            rw_d        = rw;
            we_d        = mw;
            wbwe_d      = wb_we_base & ~mw;
            ovf_d       = overflow;
            pc_src_d    = br & zero;
            pc_target_d = new_pc;
            if (!start) begin
                wb_valid_d  = 1'b1;
                wb_we_d     = wb_we_base & ~is_mem;
                wb_rw_d     = rw;
                wb_data_d   = alu_out;
                ovf_exc_d   = overflow;
                align_exc_d = is_mem;
            end
        end
        if (ack_done) begin
            wb_valid_d = 1'b1;
            wb_we_d    = wbwe_q;
            wb_rw_d    = rw_q;
            wb_data_d  = we_q ? alu_q : 32'(dm_rdata);
            ovf_exc_d  = ovf_q;
        end
        if (timeout_hit) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rw_d    = rw_q;
            wb_data_d  = alu_q;
            ovf_exc_d  = ovf_q;
            bus_err_d  = 1'b1;
        end
    end

    // Context and output registers, all cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            alu_q       <= '0;
            rw_q        <= '0;
            we_q        <= 1'b0;
            wbwe_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rw_q     <= '0;
            wb_data_q   <= '0;
            pc_src_q    <= 1'b0;
            pc_target_q <= '0;
            ovf_exc_q   <= 1'b0;
            align_exc_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            alu_q       <= alu_d;
            rw_q        <= rw_d;
            we_q        <= we_d;
            wbwe_q      <= wbwe_d;
            ovf_q       <= ovf_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rw_q     <= wb_rw_d;
            wb_data_q   <= wb_data_d;
            pc_src_q    <= pc_src_d;
            pc_target_q <= pc_target_d;
            ovf_exc_q   <= ovf_exc_d;
            align_exc_q <= align_exc_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign stall     = fsm_stall;
    assign dm_req    = fsm_req;
    assign dm_we     = fsm_req & we_q;
    assign dm_addr   = addr_q;
    assign dm_wdata  = wdata_q;
    assign pc_src    = pc_src_q;
    assign pc_target = pc_target_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rw     = wb_rw_q;
    assign wb_data   = wb_data_q;
    assign ovf_exc   = ovf_exc_q;
    assign align_exc = align_exc_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: randomized bundles checked
// against a bundle-level model of the writeback/branch/exception rules.
module tb_mem_access_stage;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clock, reset_n, ex_valid;
    logic [31:0]   alu_out, bb, new_pc;
    logic          mw, mr, br, rw_en, zero, overflow;
    logic [4:0]    rw;
    logic          stall, dm_req, dm_we, dm_ack;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          pc_src, wb_valid, wb_we, ovf_exc, align_exc, bus_err;
    logic [31:0]   pc_target, wb_data;
    logic [4:0]    wb_rw;
    logic [141:0]  all_out;

    int vectors    = 0;
    int miscompares = 0;

    mem_access_stage #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid),
        .alu_out(alu_out), .bb(bb), .mw(mw), .mr(mr), .br(br),
        .rw_en(rw_en), .rw(rw), .zero(zero), .overflow(overflow),
        .new_pc(new_pc), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ack(dm_ack), .pc_src(pc_src), .pc_target(pc_target),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data),
        .ovf_exc(ovf_exc), .align_exc(align_exc), .bus_err(bus_err)
    );

    assign all_out = {stall, dm_req, dm_we, dm_addr, dm_wdata, pc_src, pc_target,
                      wb_valid, wb_we, wb_rw, wb_data, ovf_exc, align_exc, bus_err};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Register-write rule: enabled, no overflow, not r0, and neither a store
    // nor a misaligned memory op.
    function automatic logic exp_we(input logic en, input logic [4:0] r, input logic ov,
                                    input logic m_w, input logic m_r, input logic [31:0] a);
        if ((m_w || m_r) && (a[1:0] != 2'b00)) return 1'b0;
        if (m_w) return 1'b0;
        return en && !ov && (r != 5'd0);
    endfunction

    // Random bundle offered while the stage is stalled; it must be ignored.
    task automatic drive_junk();
        ex_valid = 1'b1;
        alu_out  = $urandom;
        bb       = $urandom;
        mw       = 1'($urandom);
        mr       = 1'($urandom);
        br       = 1'($urandom);
        zero     = 1'($urandom);
        rw_en    = 1'($urandom);
        rw       = 5'($urandom);
        overflow = 1'($urandom);
        new_pc   = $urandom;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_junk();
        dm_ack   = 1'b1;
        dm_rdata = $urandom;
        tick();
        tick();
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %0h exp 0", all_out);
        end
        ex_valid = 1'b0;
        dm_ack   = 1'b0;
        reset_n  = 1'b1;
        tick();
        vectors++;
        if ({stall, dm_req, wb_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_idle got %b exp 000", {stall, dm_req, wb_valid});
        end
    endtask

    task automatic test_alu_stream();
        logic [31:0] a, np;
        logic [4:0]  r;
        logic        ev, en, ov, b, z, m_w, m_r;
        for (int i = 0; i < 48; i++) begin
            ev = 1'b1; a = $urandom; r = 5'($urandom); en = 1'($urandom);
            ov = ($urandom % 4 == 0); b = 1'($urandom); z = 1'($urandom);
            np = $urandom; m_w = 1'b0; m_r = 1'b0;
            case (i)
                0: begin a = 32'h1234; r = 5'd5; en = 1'b1; ov = 1'b0; b = 1'b0; end
                1: begin a = 32'h102; m_r = 1'b1; r = 5'd7; en = 1'b1; ov = 1'b0; b = 1'b0; end
                2: begin b = 1'b1; z = 1'b1; np = 32'h40; end
                3: begin b = 1'b1; z = 1'b0; en = 1'b0; end
                4: begin ov = 1'b1; en = 1'b1; r = 5'd3; b = 1'b0; end
                5: begin r = 5'd0; en = 1'b1; ov = 1'b0; b = 1'b0; end
                default: begin
                    ev = ($urandom % 4) != 0;
                    if ($urandom % 5 == 0) begin
                        m_w = 1'($urandom);
                        m_r = ~m_w | 1'($urandom);
                        a[1:0] = 2'($urandom_range(1, 3));
                    end
                end
            endcase
            ex_valid = ev; alu_out = a; bb = $urandom; mw = m_w; mr = m_r;
            br = b; zero = z; rw_en = en; rw = r; overflow = ov; new_pc = np;
            dm_ack = 1'($urandom); dm_rdata = $urandom;
            tick();
            vectors++;
            if ({wb_valid, pc_src, ovf_exc, align_exc, bus_err, stall, dm_req} !==
                {ev, ev & b & z, ev & ov, ev & (m_w | m_r), 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL stream_flags[%0d] got %b exp %b", i,
                         {wb_valid, pc_src, ovf_exc, align_exc, bus_err, stall, dm_req},
                         {ev, ev & b & z, ev & ov, ev & (m_w | m_r), 1'b0, 1'b0, 1'b0});
            end
            if (ev) begin
                vectors++;
                if ({wb_we, wb_rw, wb_data} !== {exp_we(en, r, ov, m_w, m_r, a), r, a}) begin
                    miscompares++;
                    $display("FAIL stream_wb[%0d] got %0h exp %0h", i, {wb_we, wb_rw, wb_data},
                             {exp_we(en, r, ov, m_w, m_r, a), r, a});
                end
            end
            if (ev & b & z) begin
                vectors++;
                if (pc_target !== np) begin
                    miscompares++;
                    $display("FAIL stream_pc_target[%0d] got %0h exp %0h", i, pc_target, np);
                end
            end
        end
        ex_valid = 1'b0;
        dm_ack   = 1'b0;
        tick();
    endtask

    task automatic test_mem_access();
        logic [31:0] a, d, rd, np;
        logic [4:0]  r;
        logic        en, ov, m_w, m_r, b, z;
        int          lat, stalls;
        for (int i = 0; i < 14; i++) begin
            a = {30'($urandom), 2'b00}; d = $urandom; rd = $urandom; np = $urandom;
            r = 5'($urandom); en = 1'($urandom); ov = ($urandom % 4 == 0);
            m_w = 1'($urandom); m_r = ~m_w | 1'($urandom);
            b = 1'($urandom); z = 1'($urandom); lat = $urandom_range(1, 8);
            if (i == 0) begin
                a = 32'h100; m_r = 1'b1; m_w = 1'b0; r = 5'd8; en = 1'b1; ov = 1'b0;
                lat = 3; rd = 32'hDEADBEEF;
            end
            if (i == 1) begin
                a = 32'h204; d = 32'hCAFE; m_w = 1'b1; m_r = 1'b0; lat = 1;
            end
            ex_valid = 1'b1; alu_out = a; bb = d; mw = m_w; mr = m_r; rw_en = en;
            rw = r; overflow = ov; br = b; zero = z; new_pc = np; dm_ack = 1'b0;
            tick();
            vectors++;
            if (pc_src !== (b & z)) begin
                miscompares++;
                $display("FAIL mem_pc_src[%0d] got %b exp %b", i, pc_src, b & z);
            end
            if (b & z) begin
                vectors++;
                if (pc_target !== np) begin
                    miscompares++;
                    $display("FAIL mem_pc_target[%0d] got %0h exp %0h", i, pc_target, np);
                end
            end
            stalls = 0;
            for (int k = 1; k <= lat; k++) begin
                vectors++;
                if ({dm_req, dm_we, dm_addr, dm_wdata, stall, wb_valid} !==
                    {1'b1, m_w, a, d, 1'b1, 1'b0}) begin
                    miscompares++;
                    $display("FAIL mem_req_hold[%0d.%0d] got %0h exp %0h", i, k,
                             {dm_req, dm_we, dm_addr, dm_wdata, stall, wb_valid},
                             {1'b1, m_w, a, d, 1'b1, 1'b0});
                end
                if (stall) stalls++;
                drive_junk();
                dm_ack   = (k == lat);
                dm_rdata = (k == lat) ? rd : $urandom;
                tick();
            end
            dm_ack = 1'b0;
            if (stall) stalls++;
            vectors++;
            if ({dm_req, stall, wb_valid, wb_we, wb_rw, ovf_exc, bus_err, align_exc, pc_src} !==
                {1'b0, 1'b1, 1'b1, exp_we(en, r, ov, m_w, m_r, a), r, ov, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL mem_done[%0d] got %b exp %b", i,
                         {dm_req, stall, wb_valid, wb_we, wb_rw, ovf_exc, bus_err, align_exc, pc_src},
                         {1'b0, 1'b1, 1'b1, exp_we(en, r, ov, m_w, m_r, a), r, ov, 1'b0, 1'b0, 1'b0});
            end
            if (m_r && !m_w) begin
                vectors++;
                if (wb_data !== rd) begin
                    miscompares++;
                    $display("FAIL load_data[%0d] got %0h exp %0h", i, wb_data, rd);
                end
            end
            drive_junk();
            tick();
            ex_valid = 1'b0;
            vectors++;
            if ({stall, dm_req, wb_valid, stalls == lat + 1} !== 4'b0001) begin
                miscompares++;
                $display("FAIL mem_release[%0d] got stall=%b req=%b wbv=%b stalls=%0d exp stalls=%0d",
                         i, stall, dm_req, wb_valid, stalls, lat + 1);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] a;
        logic [4:0]  r;
        int          reqs;
        for (int i = 0; i < 2; i++) begin
            a = {30'($urandom), 2'b00};
            r = 5'($urandom_range(1, 31));
            ex_valid = 1'b1; alu_out = a; bb = $urandom; mw = (i == 1); mr = (i == 0);
            rw_en = 1'b1; rw = r; overflow = 1'b0; br = 1'b0; zero = 1'b0; dm_ack = 1'b0;
            tick();
            reqs = 0;
            for (int k = 0; k < TIMEOUT + 4 && dm_req; k++) begin
                reqs++;
                drive_junk();
                tick();
            end
            vectors++;
            if (reqs != TIMEOUT) begin
                miscompares++;
                $display("FAIL timeout_req_cycles[%0d] got %0d exp %0d", i, reqs, TIMEOUT);
            end
            vectors++;
            if ({bus_err, wb_valid, wb_we, wb_rw, stall, dm_req, align_exc} !==
                {1'b1, 1'b1, 1'b0, r, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL timeout_done[%0d] got %b exp %b", i,
                         {bus_err, wb_valid, wb_we, wb_rw, stall, dm_req, align_exc},
                         {1'b1, 1'b1, 1'b0, r, 1'b1, 1'b0, 1'b0});
            end
            tick();
            ex_valid = 1'b0;
            vectors++;
            if ({bus_err, wb_valid, stall} !== 3'b000) begin
                miscompares++;
                $display("FAIL timeout_release[%0d] got %b exp 000", i, {bus_err, wb_valid, stall});
            end
        end
    endtask

    task automatic test_reset_mid_access();
        ex_valid = 1'b1; alu_out = 32'h80; bb = $urandom; mw = 1'b0; mr = 1'b1;
        rw_en = 1'b1; rw = 5'd9; overflow = 1'b0; br = 1'b0; zero = 1'b0; dm_ack = 1'b0;
        tick();
        drive_junk();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({dm_req, stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_drop got %b exp 00", {dm_req, stall});
        end
        ex_valid = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = $urandom;
        tick();
        dm_ack  = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({wb_valid, dm_req, stall} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_mid_no_wb[%0d] got %b exp 000", k, {wb_valid, dm_req, stall});
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; alu_out = '0; bb = '0; mw = 1'b0; mr = 1'b0;
        br = 1'b0; rw_en = 1'b0; rw = '0; zero = 1'b0; overflow = 1'b0; new_pc = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        test_reset();
        test_alu_stream();
        test_mem_access();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
